// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: owns the NCO phase increment and clock enable, applying
// host frequency words directly or as a clamped linear sweep, then flags settling.
module nco_tune_ctrl #(
  parameter int unsigned APR     = 22,
  parameter int unsigned NCO_LAT = 10,
  parameter int unsigned LAT_W   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           sample_tick,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [APR-1:0] cfg_target,
  input  logic [APR-1:0] cfg_step,
  input  logic           cfg_sweep,
  output logic [APR-1:0] phi_inc_o,
  output logic           clken_o,
  output logic           busy_o,
  output logic           settled_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_SETTLE
  } state_t;

  localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(NCO_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [APR-1:0]   r_phi;
  logic [APR-1:0]   r_target;
  logic [APR-1:0]   r_step;
  logic [APR-1:0]   w_phi_nxt;
  logic [APR-1:0]   w_target_nxt;
  logic [APR-1:0]   w_step_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;
  logic             r_clken;
  logic             r_settled;
  logic             w_settled_nxt;
  logic             w_tick;
  logic             w_xfer;
  logic             w_up;
  logic [APR:0]     w_diff;

  assign w_tick    = enable & sample_tick;
  assign cfg_ready = (r_state == S_IDLE) || (r_state == S_SETTLE);
  assign w_xfer    = cfg_valid & cfg_ready;

  // Distance to target in APR+1 bits so the clamp test cannot wrap.
  assign w_up   = r_target > r_phi;
  assign w_diff = w_up ? ({1'b0, r_target} - {1'b0, r_phi})
                       : ({1'b0, r_phi} - {1'b0, r_target});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phi_nxt     = r_phi;
    w_target_nxt  = r_target;
    w_step_nxt    = r_step;
    w_cnt_nxt     = r_cnt;
    w_settled_nxt = r_settled;
    // A transfer takes priority over a coincident tick.
    if (w_xfer) begin
      w_target_nxt  = cfg_target;
      w_step_nxt    = cfg_step;
      w_settled_nxt = 1'b0;
      w_state_nxt   = (cfg_sweep && (cfg_step != '0)) ? S_SWEEP : S_LOAD;
    end else if (w_tick) begin
      case (r_state)
        S_LOAD: begin
          w_phi_nxt   = r_target;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
        S_SWEEP: begin
          if (w_diff <= {1'b0, r_step}) begin
            w_phi_nxt   = r_target;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SETTLE;
          end else if (w_up) begin
            w_phi_nxt = r_phi + r_step;
          end else begin
            w_phi_nxt = r_phi - r_step;
          end
        end
        S_SETTLE: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_settled_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phi     <= '0;
      r_target  <= '0;
      r_step    <= '0;
      r_cnt     <= '0;
      r_clken   <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_phi     <= w_phi_nxt;
      r_target  <= w_target_nxt;
      r_step    <= w_step_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clken   <= w_tick;
      r_settled <= w_settled_nxt;
    end
  end

  assign phi_inc_o = r_phi;
  assign clken_o   = r_clken;
  assign busy_o    = (r_state == S_SWEEP);
  assign settled_o = r_settled;

endmodule
